pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage core.
- Produces the per-latch state commands (fd/dx/xm/mw) consumed by the four pipeline latches, plus the PC enable, from cache hit signals, branch/jump redirects, load-use hazards and halt.
- Tracks in-flight wrong-path fetches and the sticky halt condition.
- Sits beside the datapath, between the caches and the pipeline latch registers.

Parameters:
- REGW, 5, register-select width.
- CNT_W, 32, perf counter width (used only with HAZ_PERF_EN).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  icache returns a valid instruction this cycle.
- dhit  in  1  dcache completes the MEM-stage access this cycle.
- dmemREN_mem  in  1  load in MEM.
- dmemWEN_mem  in  1  store in MEM.
- redirect_mem  in  1  taken branch/jump resolved in MEM.
- MemRead_ex  in  1  load in EX.
- regWSEL_ex  in  REGW  EX destination register.
- rs_id  in  REGW  ID source register 1.
- rt_id  in  REGW  ID source register 2.
- uses_rt_id  in  1  ID instruction reads rt.
- halt_wb  in  1  halt instruction reached WB.
- fd_state, dx_state, xm_state, mw_state  out  pipe_state_t  PIPE_ENABLE / PIPE_STALL / PIPE_NOP command per latch.
- pc_en  out  1  PC register update enable.
- halted  out  1  core halted (sticky).
- stall_cycles  out  CNT_W  perf: cycles with pc_en=0 while not halted.
- flush_count  out  CNT_W  perf: number of redirects taken.

Behaviour:
- FSM states: RUN, SQUASH, HALTED. Reset (RST=1 at a clock edge) → RUN, counters cleared.
- Outputs are combinational from state and inputs.
- In the reset cycle all states = PIPE_NOP, pc_en=0, halted=0.
- Definitions:
  - dwait = (dmemREN_mem | dmemWEN_mem) & !dhit.
  - lu = MemRead_ex & regWSEL_ex!=0 & (regWSEL_ex==rs_id | (uses_rt_id & regWSEL_ex==rt_id)).
- RUN priority, highest first:
  1. halt_wb: all four = PIPE_STALL, pc_en=0; next state HALTED.
  2. dwait: fd/dx/xm = PIPE_STALL, mw = PIPE_NOP, pc_en=0.
  3. redirect_mem: fd/dx/xm = PIPE_NOP, mw = PIPE_ENABLE, pc_en=1 (PC loads target). flush_count+1. If !ihit this cycle, next state SQUASH (a wrong-path fetch is in flight).
  4. lu: fd = PIPE_STALL, dx = PIPE_NOP, xm/mw = PIPE_ENABLE, pc_en=0. Takes priority over !ihit.
  5. !ihit: fd = PIPE_NOP, dx/xm/mw = PIPE_ENABLE, pc_en=0.
  6. Otherwise: all PIPE_ENABLE, pc_en=1.
- SQUASH:
  - Same rules as RUN, except fd = PIPE_NOP and pc_en=0 regardless of ihit.
  - On ihit the returned instruction is discarded and next state is RUN.
  - halt_wb and dwait rules apply with their RUN priority. halt_wb → HALTED.
  - A new redirect_mem in SQUASH stays SQUASH, pc_en=1.
- HALTED: all four = PIPE_STALL, pc_en=0, halted=1. Left only by RST.
- stall_cycles increments each cycle with pc_en=0 while state != HALTED and RST=0. Counters saturate at all-ones.
- RST asserted mid-miss or mid-SQUASH: returns to RUN next cycle; no pending squash is retained.

Optional Feature:
- HAZ_PERF_EN defined: stall_cycles and flush_count are implemented as above.
- HAZ_PERF_EN not defined: both outputs are constant 0, and no counter flops are synthesized.

Test Plan:
- Reset then ihit=1, no hazards → all PIPE_ENABLE, pc_en=1 from the first post-reset cycle.
- MemRead_ex=1, regWSEL_ex=5, rs_id=5, ihit=1 → one cycle fd=STALL, dx=NOP, xm=ENABLE, mw=ENABLE, pc_en=0. With regWSEL_ex=0 → no stall.
- dmemREN_mem=1, dhit=0 for 3 cycles then dhit=1 → 3 cycles of fd/dx/xm=STALL, mw=NOP, pc_en=0; all ENABLE on the dhit cycle; stall_cycles=3 (with HAZ_PERF_EN).
- redirect_mem=1 with ihit=0, then ihit=0 for 2 cycles, ihit=1 → fd/dx/xm=NOP on the redirect cycle; fd=NOP and pc_en=0 through the ihit cycle; RUN resumes the cycle after; flush_count=1.
- redirect_mem=1 and dmemWEN_mem=1 with dhit=0 in the same cycle → dwait wins: mw=NOP, no flush, flush_count unchanged.
- halt_wb=1 during a load-use stall → HALTED, halted=1, all STALL; held for 10 cycles; RST=1 → RUN, halted=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central control for the 5-stage core.
// Drives the fd/dx/xm/mw latch commands and the PC enable from the cache hits,
// MEM-stage redirects, load-use hazards and halt. It also tracks a wrong-path
// fetch that is still in flight (SQUASH) and the sticky halt (HALTED).
// Optional feature macro: HAZ_PERF_EN enables the stall_cycles and flush_count
// perf counters. Without it both outputs are tied to zero and no counter flops
// are built.

package pipeline_hazard_pkg;
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,
    PIPE_STALL  = 2'b01,
    PIPE_NOP    = 2'b10
  } pipe_state_t;
endpackage

module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int REGW  = 5,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmemREN_mem,
  input  logic              dmemWEN_mem,
  input  logic              redirect_mem,
  input  logic              MemRead_ex,
  input  logic [REGW-1:0]   regWSEL_ex,
  input  logic [REGW-1:0]   rs_id,
  input  logic [REGW-1:0]   rt_id,
  input  logic              uses_rt_id,
  input  logic              halt_wb,
  output pipe_state_t       fd_state,
  output pipe_state_t       dx_state,
  output pipe_state_t       xm_state,
  output pipe_state_t       mw_state,
  output logic              pc_en,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SQUASH = 2'b01,
    HALTED = 2'b10
  } ctrl_state_t;

  ctrl_state_t state_r;
  ctrl_state_t state_next_s;
  logic        dwait_s;
  logic        lu_s;
  logic        squash_s;

  // Hazard detection: a MEM access waiting on the dcache, and a load in EX
  // whose destination feeds the instruction in ID ($0 never creates a hazard).
  always_comb begin
    dwait_s  = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    lu_s     = MemRead_ex & (regWSEL_ex != {REGW{1'b0}}) &
               ((regWSEL_ex == rs_id) | (uses_rt_id & (regWSEL_ex == rt_id)));
    squash_s = (state_r == SQUASH);
  end

  // Next state and latch commands. SQUASH shares the RUN rules, but it also
  // drops whatever the icache returns and keeps the PC frozen.
  always_comb begin
    fd_state     = PIPE_ENABLE;
    dx_state     = PIPE_ENABLE;
    xm_state     = PIPE_ENABLE;
    mw_state     = PIPE_ENABLE;
    pc_en        = 1'b0;
    halted       = 1'b0;
    state_next_s = state_r;
    if (RST) begin
      fd_state     = PIPE_NOP;
      dx_state     = PIPE_NOP;
      xm_state     = PIPE_NOP;
      mw_state     = PIPE_NOP;
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN, SQUASH: begin
          if (halt_wb) begin
            fd_state     = PIPE_STALL;
            dx_state     = PIPE_STALL;
            xm_state     = PIPE_STALL;
            mw_state     = PIPE_STALL;
            state_next_s = HALTED;
          end else if (dwait_s) begin
            fd_state = squash_s ? PIPE_NOP : PIPE_STALL;
            dx_state = PIPE_STALL;
            xm_state = PIPE_STALL;
            mw_state = PIPE_NOP;
            // The wrong-path fetch can still land during a dcache wait.
            if (squash_s && ihit) begin
              state_next_s = RUN;
            end else begin
              state_next_s = state_r;
            end
          end else if (redirect_mem) begin
            fd_state = PIPE_NOP;
            dx_state = PIPE_NOP;
            xm_state = PIPE_NOP;
            mw_state = PIPE_ENABLE;
            pc_en    = 1'b1;
            // A fetch still outstanding at redirect time is from the wrong path.
            if (squash_s || !ihit) begin
              state_next_s = SQUASH;
            end else begin
              state_next_s = RUN;
            end
          end else if (lu_s) begin
            fd_state = squash_s ? PIPE_NOP : PIPE_STALL;
            dx_state = PIPE_NOP;
            if (squash_s && ihit) begin
              state_next_s = RUN;
            end else begin
              state_next_s = state_r;
            end
          end else if (!ihit) begin
            fd_state     = PIPE_NOP;
            state_next_s = state_r;
          end else begin
            fd_state     = squash_s ? PIPE_NOP : PIPE_ENABLE;
            pc_en        = ~squash_s;
            state_next_s = RUN;
          end
        end
        HALTED: begin
          fd_state     = PIPE_STALL;
          dx_state     = PIPE_STALL;
          xm_state     = PIPE_STALL;
          mw_state     = PIPE_STALL;
          halted       = 1'b1;
          state_next_s = HALTED;
        end
        default: begin
          fd_state     = PIPE_NOP;
          dx_state     = PIPE_NOP;
          xm_state     = PIPE_NOP;
          mw_state     = PIPE_NOP;
          state_next_s = RUN;
        end
      endcase
    end
  end

  // Control state register. Reset always returns to RUN, so no squash survives it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

`ifdef HAZ_PERF_EN
  logic             flush_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // A redirect is taken only when neither halt nor a dcache wait outranks it.
  always_comb begin
    flush_s = ((state_r == RUN) | (state_r == SQUASH)) & ~halt_wb & ~dwait_s & redirect_mem;
  end

  // Saturating perf counters. Cycles spent halted are not counted as stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en && (state_r != HALTED) && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Each cycle pushes the expected
// latch commands and counters to a scoreboard, then pops them and compares
// them with the DUT outputs on the falling edge.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_pkg::*;

  localparam pipe_state_t E = PIPE_ENABLE;
  localparam pipe_state_t S = PIPE_STALL;
  localparam pipe_state_t N = PIPE_NOP;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, dmemREN_mem, dmemWEN_mem, redirect_mem;
  logic        MemRead_ex, uses_rt_id, halt_wb;
  logic [4:0]  regWSEL_ex, rs_id, rt_id;
  pipe_state_t fd_state, dx_state, xm_state, mw_state;
  logic        pc_en, halted;
  logic [31:0] stall_cycles, flush_count;

  typedef struct {
    pipe_state_t fd, dx, xm, mw;
    logic        pc, hl;
    logic [31:0] st, fl;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_st = 32'd0;
  logic [31:0] m_fl = 32'd0;

  pipeline_hazard_ctrl #(.REGW(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .redirect_mem(redirect_mem), .MemRead_ex(MemRead_ex),
    .regWSEL_ex(regWSEL_ex), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id), .halt_wb(halt_wb),
    .fd_state(fd_state), .dx_state(dx_state), .xm_state(xm_state),
    .mw_state(mw_state), .pc_en(pc_en), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs, push the expectation, pop and compare.
  task automatic cyc(input logic r, input logic ih, input logic dh, input logic rn,
                     input logic wn, input logic rd, input logic mr,
                     input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                     input logic ur, input logic hw,
                     input pipe_state_t efd, input pipe_state_t edx,
                     input pipe_state_t exm, input pipe_state_t emw,
                     input logic epc, input logic ehl);
    exp_t e;
    exp_t got;
    @(posedge CLK);
    #1;
    RST = r; ihit = ih; dhit = dh; dmemREN_mem = rn; dmemWEN_mem = wn;
    redirect_mem = rd; MemRead_ex = mr; regWSEL_ex = ws; rs_id = rs; rt_id = rt;
    uses_rt_id = ur; halt_wb = hw;
    e.fd = efd; e.dx = edx; e.xm = exm; e.mw = emw; e.pc = epc; e.hl = ehl;
`ifdef HAZ_PERF_EN
    e.st = m_st; e.fl = m_fl;
`else
    e.st = 32'd0; e.fl = 32'd0;
`endif
    sb.push_back(e);
    if (r) begin
      m_st = 32'd0;
      m_fl = 32'd0;
    end else begin
      if (!epc && !ehl) m_st = m_st + 32'd1;
      if (exm == N && emw == E) m_fl = m_fl + 32'd1;
    end
    @(negedge CLK);
    got = sb.pop_front();
    chk("fd_state", 32'(fd_state), 32'(got.fd));
    chk("dx_state", 32'(dx_state), 32'(got.dx));
    chk("xm_state", 32'(xm_state), 32'(got.xm));
    chk("mw_state", 32'(mw_state), 32'(got.mw));
    chk("pc_en", 32'(pc_en), 32'(got.pc));
    chk("halted", 32'(halted), 32'(got.hl));
    chk("stall_cycles", stall_cycles, got.st);
    chk("flush_count", flush_count, got.fl);
  endtask

  // Idle cycle with the icache hitting and no hazards.
  task automatic idle(input pipe_state_t efd, input pipe_state_t edx,
                      input pipe_state_t exm, input pipe_state_t emw,
                      input logic epc, input logic ehl);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0,
        efd, edx, exm, emw, epc, ehl);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    redirect_mem = 1'b0; MemRead_ex = 1'b0; regWSEL_ex = 5'd0; rs_id = 5'd0;
    rt_id = 5'd0; uses_rt_id = 1'b0; halt_wb = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset cycle, then plain running from the first post-reset cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, N, N, N, 1'b0, 1'b0);
    repeat (3) idle(E, E, E, E, 1'b1, 1'b0);

    // Load-use on rs, then $0 destination (no hazard), then rt with/without uses_rt.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, S, N, E, E, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E, E, E, E, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, S, N, E, E, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, E, E, E, E, 1'b1, 1'b0);
    // Load-use outranks an icache miss.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, S, N, E, E, 1'b0, 1'b0);
    // Plain icache miss.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, E, E, E, 1'b0, 1'b0);

    // Dcache load miss for three cycles, then the hit.
    repeat (3)
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S, S, S, N, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E, E, E, E, 1'b1, 1'b0);
    idle(E, E, E, E, 1'b1, 1'b0);

    // Redirect with a miss in flight: SQUASH until the wrong-path fetch lands.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, N, N, E, 1'b1, 1'b0);
    repeat (2)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, E, E, E, 1'b0, 1'b0);
    idle(N, E, E, E, 1'b0, 1'b0);
    idle(E, E, E, E, 1'b1, 1'b0);

    // Redirect blocked by a store waiting on the dcache: no flush.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, S, S, S, N, 1'b0, 1'b0);
    idle(E, E, E, E, 1'b1, 1'b0);

    // Reset in the middle of SQUASH leaves no squash pending.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, N, N, E, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, N, N, N, 1'b0, 1'b0);
    idle(E, E, E, E, 1'b1, 1'b0);

    // Halt during a load-use stall, held for 10 cycles, then released by reset.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, S, S, S, S, 1'b0, 1'b0);
    repeat (10) idle(S, S, S, S, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, N, N, N, N, 1'b0, 1'b0);
    idle(E, E, E, E, 1'b1, 1'b0);
    idle(E, E, E, E, 1'b1, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
